simple_dual_port_sram: RTL

SIMPLE_DUAL_PORT_SRAM -- requirements
Module: simple_dual_port_sram

---
 rtl/simple_dual_port_sram_pkg.sv | 28 ++
 rtl/simple_dual_port_sram_byte_merge.sv | 34 +++
 rtl/simple_dual_port_sram.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/simple_dual_port_sram_pkg.sv
// ---------------------------------------------------------------------------
// simple_dual_port_sram_pkg
//   Shared SRAM definitions used by every SRAM block in this slice.
//   Holds the read-during-write mode encodings and the byte-lane width.
//   The file is include-guarded so it can be pulled into several
//   compilation units without redefinition errors.
//   No ports (package).
// ---------------------------------------------------------------------------
`ifndef SIMPLE_DUAL_PORT_SRAM_PKG_SV
`define SIMPLE_DUAL_PORT_SRAM_PKG_SV

package simple_dual_port_sram_pkg;

  // Result returned when a read and a write hit the same word in one cycle.
  typedef enum int {
    RDW_OLD_DATA = 0,
    RDW_NEW_DATA = 1
  } rdw_mode_e;

  // Width of one write-mask lane.
  localparam int SRAM_BYTE_WIDTH = 8;

  // Deepest read pipeline supported by the SRAM blocks.
  localparam int SRAM_MAX_READ_LATENCY = 2;

endpackage

`endif

// File: rtl/simple_dual_port_sram_byte_merge.sv
// ---------------------------------------------------------------------------
// sram_byte_merge
//   Combinational byte-lane merge: each byte of merged_word comes from
//   new_word when its mask bit is set, otherwise from old_word.
//   Ports:
//     old_word    in  WIDTH            current contents of the word
//     new_word    in  WIDTH            incoming write data
//     mask        in  WIDTH/8          per-byte select, bit i -> byte i
//     merged_word out WIDTH            resulting word
// ---------------------------------------------------------------------------
module sram_byte_merge
  import simple_dual_port_sram_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]                 old_word,
  input  logic [WIDTH-1:0]                 new_word,
  input  logic [WIDTH/SRAM_BYTE_WIDTH-1:0] mask,
  output logic [WIDTH-1:0]                 merged_word
);

  localparam int NUM_BYTES = WIDTH / SRAM_BYTE_WIDTH;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (mask[i]) begin
        merged_word[i*SRAM_BYTE_WIDTH +: SRAM_BYTE_WIDTH] =
          new_word[i*SRAM_BYTE_WIDTH +: SRAM_BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/simple_dual_port_sram.sv
// ---------------------------------------------------------------------------
// simple_dual_port_sram
//   One write port and one read port on a single clock, byte-maskable
//   writes, registered read data with a 1- or 2-stage read pipeline.
//   Addresses at or beyond DEPTH are ignored on write and read back as 0.
//   The memory array itself is never reset; only the read pipeline is.
//   Parameters:
//     WIDTH        word width in bits, multiple of 8
//     DEPTH        number of words (any value >= 2)
//     READ_LATENCY 1 or 2 clock edges from read request to rd_valid
//     RDW_MODE     same-address read-during-write: 0 old data, 1 new data
//   Ports:
//     clk      in   single clock, rising edge
//     rst      in   asynchronous active-high reset of the read pipeline
//     wr_en    in   write request
//     wr_addr  in   write word address
//     wr_data  in   write data
//     wr_mask  in   per-byte write enable
//     rd_en    in   read request
//     rd_addr  in   read word address
//     rd_data  out  registered read data, holds between reads
//     rd_valid out  one-cycle pulse per completed read
// ---------------------------------------------------------------------------
module simple_dual_port_sram
  import simple_dual_port_sram_pkg::*;
#(
  parameter  int WIDTH        = 32,
  parameter  int DEPTH        = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int NUM_BYTES    = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NUM_BYTES-1:0]  wr_mask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid
);

  // One extra bit so the limit compare also works when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             rdw_bypass;
  logic [WIDTH-1:0] wr_old_word;
  logic [WIDTH-1:0] wr_merged_word;
  logic [WIDTH-1:0] rd_array_word;
  logic [WIDTH-1:0] rd_word;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);

  // Array lookups are gated by the range check so an out-of-range address
  // never indexes past the end of the array; such reads return zero.
  always_comb begin
    wr_old_word   = '0;
    rd_array_word = '0;
    if (wr_in_range) begin
      wr_old_word = mem[wr_addr];
    end
    if (rd_in_range) begin
      rd_array_word = mem[rd_addr];
    end
  end

  // A single merge instance serves both the array update and the
  // new-data bypass: on a same-address collision the word being written
  // is exactly the word the reader should see.
  sram_byte_merge #(
    .WIDTH (WIDTH)
  ) u_byte_merge (
    .old_word    (wr_old_word),
    .new_word    (wr_data),
    .mask        (wr_mask),
    .merged_word (wr_merged_word)
  );

  // In old-data mode no bypass is needed: the array read above sees the
  // contents before this edge's write lands.
  assign rdw_bypass = (RDW_MODE == int'(RDW_NEW_DATA)) && wr_en &&
                      wr_in_range && rd_in_range && (wr_addr == rd_addr);

  assign rd_word = rdw_bypass ? wr_merged_word : rd_array_word;

  // Writing back the merged word leaves unmasked bytes unchanged, so a
  // zero mask is a harmless rewrite of the old value.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_merged_word;
    end
  end

  // First read stage: data only updates on a read so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY >= SRAM_MAX_READ_LATENCY) begin : g_two_stage
      logic             s2_valid;
      logic [WIDTH-1:0] s2_data;

      // Second stage copies the first every cycle; since s1_data already
      // holds between reads, s2_data holds too.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_data  <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_one_stage
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule
